// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative RV32M multiply controller for MUL/MULH/MULHSU/MULHU.
// Latency: result and valid appear N+2 edges after the start edge (N = 32/SIZE); busy is high for N+1 cycles.
// Backpressure: no queueing; start is only accepted in IDLE, and flush/rst abort at the next edge.
// Ports: clk, rst (synchronous, active-high); start/op/rs1/rs2 issue a request; flush aborts it;
//        busy drives the pipeline stall; valid is a one-cycle strobe; result is the registered product word.

// mul_sub_unit: one combinational shift-add step that retires SIZE multiplier bits.
// Ports: product_i running sum, mcand_i pre-shifted multiplicand, mplier_i multiplier chunk,
//        product_o = product_i + mcand_i * mplier_i.
module mul_sub_unit #(
  parameter int unsigned SIZE = 8
) (
  input  logic [63:0]     product_i,
  input  logic [63:0]     mcand_i,
  input  logic [SIZE-1:0] mplier_i,
  output logic [63:0]     product_o
);

  always_comb begin
    product_o = product_i;
    for (int j = 0; j < SIZE; j++) begin
      if (mplier_i[j]) product_o = product_o + (mcand_i << j);
    end
  end

endmodule

module mul_seq_ctrl #(
  parameter int unsigned SIZE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        busy,
  output logic        valid,
  output logic [31:0] result
);

  localparam int unsigned N    = 32 / SIZE;
  localparam logic [5:0]  LAST = 6'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [63:0] acc_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [5:0]  cnt_q;
  logic        neg_q;
  logic        hi_q;
  logic        pend_q;      // DONE has produced a result that is published on the next edge
  logic [31:0] pend_res_q;
  logic        busy_q;
  logic        valid_q;
  logic [31:0] result_q;

  // Operand conditioning: rs1 is signed for MULH/MULHSU, rs2 only for MULH.
  // Negating 0x80000000 in 32 bits yields 0x80000000, which is the correct unsigned magnitude.
  logic        rs1_neg;
  logic        rs2_neg;
  logic [31:0] rs1_mag;
  logic [31:0] rs2_mag;

  assign rs1_neg = rs1[31] & ((op == 2'b01) | (op == 2'b10));
  assign rs2_neg = rs2[31] & (op == 2'b01);
  assign rs1_mag = rs1_neg ? (~rs1 + 32'd1) : rs1;
  assign rs2_mag = rs2_neg ? (~rs2 + 32'd1) : rs2;

  // Step datapath: chunk cnt of the multiplier against the multiplicand shifted into place.
  logic [4:0]      shamt;
  logic [63:0]     mcand_sh;
  logic [SIZE-1:0] chunk;
  logic [63:0]     acc_d;

  assign shamt    = 5'(32'(cnt_q) * SIZE);
  assign mcand_sh = {32'd0, mcand_q} << shamt;
  assign chunk    = mplier_q[shamt +: SIZE];

  mul_sub_unit #(.SIZE(SIZE)) u_sub (
    .product_i (acc_q),
    .mcand_i   (mcand_sh),
    .mplier_i  (chunk),
    .product_o (acc_d)
  );

  // Sign fix-up and word select, used while in DONE.
  logic [63:0] prod_d;
  logic [31:0] res_d;

  assign prod_d = neg_q ? (~acc_q + 64'd1) : acc_q;
  assign res_d  = hi_q ? prod_d[63:32] : prod_d[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      hi_q       <= 1'b0;
      pend_q     <= 1'b0;
      pend_res_q <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      result_q   <= '0;
    end else if (flush) begin
      // Abort whatever is in flight, including a result still waiting to be published.
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= pend_q;
      pend_q  <= 1'b0;
      if (pend_q) result_q <= pend_res_q;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            mcand_q  <= rs1_mag;
            mplier_q <= rs2_mag;
            neg_q    <= rs1_neg ^ rs2_neg;
            hi_q     <= (op != 2'b00);
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LAST) state_q <= S_DONE;
        end
        S_DONE: begin
          pend_q     <= 1'b1;
          pend_res_q <= res_d;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign valid  = valid_q;
  assign result = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
module tb_mul_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Three instances: index 0 -> SIZE=8, 1 -> SIZE=1, 2 -> SIZE=32.
  logic        rst_v    [3];
  logic        start_v  [3];
  logic        flush_v  [3];
  logic [1:0]  op_v     [3];
  logic [31:0] rs1_v    [3];
  logic [31:0] rs2_v    [3];
  logic        busy_v   [3];
  logic        valid_v  [3];
  logic [31:0] result_v [3];
  logic [31:0] last_res [3];

  int nchk  = 0;
  int nfail = 0;

  mul_seq_ctrl #(.SIZE(8)) u_s8 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .op(op_v[0]), .rs1(rs1_v[0]), .rs2(rs2_v[0]),
    .flush(flush_v[0]), .busy(busy_v[0]), .valid(valid_v[0]), .result(result_v[0])
  );
  mul_seq_ctrl #(.SIZE(1)) u_s1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .op(op_v[1]), .rs1(rs1_v[1]), .rs2(rs2_v[1]),
    .flush(flush_v[1]), .busy(busy_v[1]), .valid(valid_v[1]), .result(result_v[1])
  );
  mul_seq_ctrl #(.SIZE(32)) u_s32 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .op(op_v[2]), .rs1(rs1_v[2]), .rs2(rs2_v[2]),
    .flush(flush_v[2]), .busy(busy_v[2]), .valid(valid_v[2]), .result(result_v[2])
  );

  function automatic int nof(input int k);
    return (k == 0) ? 4 : (k == 1) ? 32 : 1;
  endfunction

  // Reference: full 64-bit products by plain multiplication of sign- or zero-extended operands.
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00:   begin p = sa * sb; return p[31:0];  end
      2'b01:   begin p = sa * sb; return p[63:32]; end
      2'b10:   begin p = sa * ub; return p[63:32]; end
      default: begin p = ua * ub; return p[63:32]; end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int k);
    int t;
    t = 0;
    while (busy_v[k] && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk($sformatf("idle_wait_k%0d", k), {31'd0, busy_v[k]}, 32'd0);
  endtask

  // One multiply: checks busy length, single valid at E+N+2, result value and hold.
  // With poke set, start is held high with junk operands through BUSY/DONE; it must be ignored.
  task automatic run_mul(input int k, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input bit poke);
    int n, bcnt, vcnt, vidx;
    logic [31:0] exp, got;
    n    = nof(k);
    exp  = ref_mul(o, a, b);
    got  = 'x;
    vidx = -1;
    wait_idle(k);
    op_v[k] = o; rs1_v[k] = a; rs2_v[k] = b; start_v[k] = 1'b1;
    @(posedge clk); #1;  // start edge E
    start_v[k] = poke;
    if (poke) begin
      rs1_v[k] = $urandom; rs2_v[k] = $urandom; op_v[k] = 2'($urandom_range(0, 3));
    end
    bcnt = busy_v[k] ? 1 : 0;
    vcnt = valid_v[k] ? 1 : 0;
    for (int i = 1; i <= n + 4; i++) begin
      @(posedge clk); #1;
      if (i == n) start_v[k] = 1'b0;
      if (busy_v[k]) bcnt++;
      if (valid_v[k]) begin
        vcnt++;
        vidx = i;
        got  = result_v[k];
      end
    end
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(n + 1));
    chk({tag, "_valid_count"}, 32'(vcnt), 32'd1);
    chk({tag, "_valid_edge"},  32'(vidx), 32'(n + 2));
    chk({tag, "_result"},      got,       exp);
    chk({tag, "_result_hold"}, result_v[k], exp);
    last_res[k] = exp;
  endtask

  task automatic run_flush(input int k);
    int n, vcnt;
    n = nof(k);
    wait_idle(k);
    // flush together with start in IDLE: nothing starts
    op_v[k] = 2'b00; rs1_v[k] = 32'd3; rs2_v[k] = 32'd5; start_v[k] = 1'b1; flush_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0; flush_v[k] = 1'b0;
    chk($sformatf("flush_start_busy_k%0d", k), {31'd0, busy_v[k]}, 32'd0);
    // flush in the second BUSY cycle
    rs1_v[k] = $urandom; rs2_v[k] = $urandom; start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    @(posedge clk); #1;
    flush_v[k] = 1'b1;
    @(posedge clk); #1;
    flush_v[k] = 1'b0;
    chk($sformatf("flush_busy_k%0d", k),  {31'd0, busy_v[k]},  32'd0);
    chk($sformatf("flush_valid_k%0d", k), {31'd0, valid_v[k]}, 32'd0);
    vcnt = 0;
    repeat (n + 4) begin
      @(posedge clk); #1;
      if (valid_v[k]) vcnt++;
    end
    chk($sformatf("flush_no_valid_k%0d", k), 32'(vcnt), 32'd0);
    chk($sformatf("flush_result_kept_k%0d", k), result_v[k], last_res[k]);
  endtask

  task automatic run_reset(input int k);
    int n, vcnt;
    n = nof(k);
    wait_idle(k);
    op_v[k] = 2'b11; rs1_v[k] = 32'hDEAD_BEEF; rs2_v[k] = 32'h1234_5678; start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    @(posedge clk); #1;
    rst_v[k] = 1'b1;
    @(posedge clk); #1;
    rst_v[k] = 1'b0;
    chk($sformatf("rst_busy_k%0d", k),   {31'd0, busy_v[k]},  32'd0);
    chk($sformatf("rst_valid_k%0d", k),  {31'd0, valid_v[k]}, 32'd0);
    chk($sformatf("rst_result_k%0d", k), result_v[k],         32'd0);
    vcnt = 0;
    repeat (n + 4) begin
      @(posedge clk); #1;
      if (valid_v[k]) vcnt++;
    end
    chk($sformatf("rst_no_valid_k%0d", k), 32'(vcnt), 32'd0);
    last_res[k] = 32'd0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_v[k] = 1'b1; start_v[k] = 1'b0; flush_v[k] = 1'b0;
      op_v[k] = 2'b00; rs1_v[k] = '0; rs2_v[k] = '0; last_res[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst_v[k] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_busy_k%0d", k),   {31'd0, busy_v[k]},  32'd0);
      chk($sformatf("reset_valid_k%0d", k),  {31'd0, valid_v[k]}, 32'd0);
      chk($sformatf("reset_result_k%0d", k), result_v[k],         32'd0);
    end

    for (int k = 0; k < 3; k++) begin
      run_mul(k, 2'b00, 32'd7, 32'd6, $sformatf("mul7x6_k%0d", k), 1'b0);
      chk($sformatf("mul7x6_const_k%0d", k), result_v[k], 32'h0000_002A);
      run_mul(k, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, $sformatf("mulh_m1_k%0d", k), 1'b0);
      chk($sformatf("mulh_m1_const_k%0d", k), result_v[k], 32'h0000_0000);
      run_mul(k, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, $sformatf("mulhu_max_k%0d", k), 1'b0);
      chk($sformatf("mulhu_max_const_k%0d", k), result_v[k], 32'hFFFF_FFFE);
      run_mul(k, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, $sformatf("mul_m1_k%0d", k), 1'b0);
      chk($sformatf("mul_m1_const_k%0d", k), result_v[k], 32'h0000_0001);
      run_mul(k, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, $sformatf("mulhsu_k%0d", k), 1'b0);
      chk($sformatf("mulhsu_const_k%0d", k), result_v[k], 32'hFFFF_FFFF);
      run_mul(k, 2'b01, 32'h8000_0000, 32'h8000_0000, $sformatf("mulh_min_poke_k%0d", k), 1'b1);
      chk($sformatf("mulh_min_const_k%0d", k), result_v[k], 32'h4000_0000);
      run_mul(k, 2'b00, 32'h8000_0000, 32'h8000_0000, $sformatf("mul_min_k%0d", k), 1'b0);
      chk($sformatf("mul_min_const_k%0d", k), result_v[k], 32'h0000_0000);

      run_flush(k);
      run_mul(k, 2'b01, 32'hFFFF_FFF9, 32'd6, $sformatf("after_flush_k%0d", k), 1'b0);
      run_reset(k);
      run_mul(k, 2'b10, 32'h8000_0001, 32'hF000_0000, $sformatf("after_rst_k%0d", k), 1'b0);

      for (int r = 0; r < 6; r++) begin
        run_mul(k, 2'($urandom_range(0, 3)), $urandom, $urandom,
                $sformatf("rand%0d_k%0d", r, k), 1'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule
